// File: rtl/cnt_mon_pkg.sv
// ---------------------------------------------------------------------------
// cnt_mon_pkg
// Shared definitions for the count event monitor: default widths, the
// monitor FSM state encoding and the per-edge step classification.
// ---------------------------------------------------------------------------
package cnt_mon_pkg;

    localparam int unsigned CNT_W   = 8;   // default width of monitored count
    localparam int unsigned TALLY_W = 16;  // default width of event tallies

    // Largest count value for the default width (wrap boundary).
    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    typedef enum logic [1:0] {
        S_INIT,   // no valid previous sample yet
        S_SYNC,   // previous sample valid, step direction unknown
        S_TRACK   // direction known, reversals are tracked
    } state_e;

    typedef enum logic [1:0] {
        STEP_UP,    // count - prev == +1
        STEP_DN,    // count - prev == -1 (mod 2^W)
        STEP_HOLD,  // count unchanged
        STEP_JUMP   // any other difference
    } step_e;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the wrap and reversal tallies. Holds at
// all-ones instead of rolling over. Clear and reset both force zero; a
// clear in the same cycle as an increment wins.
//
// Ports
//   clk_i    in   1   clock, rising edge
//   reset_i  in   1   synchronous, active-high reset
//   inc_i    in   1   count one event this cycle
//   clr_i    in   1   synchronous clear
//   q_o      out  CW  current tally
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] q_o
);

    logic [CW-1:0] q_q;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            q_q <= '0;
        end else if (inc_i && (q_q != '1)) begin
            q_q <= q_q + CW'(1);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/count_event_monitor.sv
// ---------------------------------------------------------------------------
// count_event_monitor
// Watches the count/dir outputs of an up/down counter and classifies the
// step seen at every clock edge. Reports wrap-arounds, direction reversals,
// illegal jumps and steps that disagree with the applied direction as
// one-cycle registered pulses, and keeps saturating wrap/reversal tallies.
//
// Ports
//   clk_i       in   1   clock, rising edge
//   reset_i     in   1   synchronous, active-high reset, highest priority
//   count_i     in   W   counter value, sampled every edge
//   dir_i       in   1   direction applied to the counter (1 = up)
//   clr_i       in   1   synchronous clear of the two tallies only
//   wrap_up_o   out  1   pulse: MAX -> 0 step observed
//   wrap_dn_o   out  1   pulse: 0 -> MAX step observed
//   reversal_o  out  1   pulse: step opposite to last nonzero step
//   jump_err_o  out  1   pulse: illegal step
//   dir_err_o   out  1   pulse: +-1 step disagrees with the applied dir
//   dir_obs_o   out  1   last observed nonzero step direction (1 = up)
//   locked_o    out  1   high while tracking direction (S_TRACK)
//   wrap_cnt_o  out  CW  saturating tally of wrap events
//   rev_cnt_o   out  CW  saturating tally of reversal events
// ---------------------------------------------------------------------------
module count_event_monitor
    import cnt_mon_pkg::*;
#(
    parameter int unsigned W       = CNT_W,
    parameter int unsigned CW      = TALLY_W,
    parameter bit          HOLD_OK = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [W-1:0]  count_i,
    input  logic          dir_i,
    input  logic          clr_i,
    output logic          wrap_up_o,
    output logic          wrap_dn_o,
    output logic          reversal_o,
    output logic          jump_err_o,
    output logic          dir_err_o,
    output logic          dir_obs_o,
    output logic          locked_o,
    output logic [CW-1:0] wrap_cnt_o,
    output logic [CW-1:0] rev_cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    state_e       state_q;
    logic [W-1:0] prev_q;
    logic         dir_q;
    logic         dir_obs_q;
    logic         locked_q;
    logic         wrap_up_q, wrap_dn_q, reversal_q, jump_err_q, dir_err_q;

    logic [W-1:0] step;
    step_e        step_cls;
    logic         is_move, move_up, active;
    logic         wrap_up_d, wrap_dn_d, reversal_d, jump_err_d, dir_err_d;

    // Step classifier: difference modulo 2^W against the previous sample.
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        step     = count_i - prev_q;
        step_cls = STEP_JUMP;
        if (step == W'(1)) begin
            step_cls = STEP_UP;
        end else if (step == '1) begin
            step_cls = STEP_DN;
        end else if (step == '0) begin
            step_cls = STEP_HOLD;
        end
    end

    // Event decode for this edge; nothing is flagged until prev_q is valid.
    always_comb begin
        active  = (state_q != S_INIT);
        is_move = (step_cls == STEP_UP) || (step_cls == STEP_DN);
        move_up = (step_cls == STEP_UP);

        wrap_up_d  = active && (step_cls == STEP_UP) && (prev_q == CNT_MAX);
        wrap_dn_d  = active && (step_cls == STEP_DN) && (prev_q == '0);
        reversal_d = (state_q == S_TRACK) && is_move && (move_up != dir_obs_q);
        jump_err_d = active && ((step_cls == STEP_JUMP) ||
                                ((step_cls == STEP_HOLD) && !HOLD_OK));
        dir_err_d  = active && is_move && (move_up != dir_q);
    end

    // FSM, sample history and pulse registers.
    // NOTE: the synchronous reset is tested first, so it overrides every
    // other update in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_INIT;
            prev_q     <= '0;
            dir_q      <= 1'b0;
            dir_obs_q  <= 1'b0;
            locked_q   <= 1'b0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            reversal_q <= 1'b0;
            jump_err_q <= 1'b0;
            dir_err_q  <= 1'b0;
        end else begin
            prev_q     <= count_i;
            dir_q      <= dir_i;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            reversal_q <= reversal_d;
            jump_err_q <= jump_err_d;
            dir_err_q  <= dir_err_d;

            case (state_q)
                S_INIT: begin
                    // This sample only seeds prev_q.
                    state_q  <= S_SYNC;
                    locked_q <= 1'b0;
                end
                S_SYNC: begin
                    if (is_move) begin
                        dir_obs_q <= move_up;
                        state_q   <= S_TRACK;
                        locked_q  <= 1'b1;
                    end
                end
                S_TRACK: begin
                    if (is_move) begin
                        // Same direction leaves dir_obs unchanged; opposite flips it.
                        dir_obs_q <= move_up;
                    end else if (jump_err_d) begin
                        state_q  <= S_SYNC;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_INIT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // wrap_up and wrap_dn are mutually exclusive, so one increment suffices.
    sat_counter #(.CW(CW)) u_wrap_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (wrap_up_d | wrap_dn_d),
        .clr_i   (clr_i),
        .q_o     (wrap_cnt_o)
    );

    sat_counter #(.CW(CW)) u_rev_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (reversal_d),
        .clr_i   (clr_i),
        .q_o     (rev_cnt_o)
    );

    assign wrap_up_o  = wrap_up_q;
    assign wrap_dn_o  = wrap_dn_q;
    assign reversal_o = reversal_q;
    assign jump_err_o = jump_err_q;
    assign dir_err_o  = dir_err_q;
    assign dir_obs_o  = dir_obs_q;
    assign locked_o   = locked_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_event_monitor
// Directed scoreboard bench. dut_a is the default build (HOLD_OK=1, CW=16),
// dut_b is HOLD_OK=0 with 4-bit tallies. Only the selected instance is out
// of reset. Each driven vector pushes its hand-computed expected outputs;
// a monitor pops one entry after every rising edge and compares.
// Pulse bit order: {wrap_up, wrap_dn, reversal, jump_err, dir_err}.
// ---------------------------------------------------------------------------
module tb_count_event_monitor;

    localparam logic [4:0] P0   = 5'b00000;
    localparam logic [4:0] P_WU = 5'b10000;
    localparam logic [4:0] P_WD = 5'b01000;
    localparam logic [4:0] P_RV = 5'b00100;
    localparam logic [4:0] P_JE = 5'b00010;
    localparam logic [4:0] P_DE = 5'b00001;

    logic       clk_i = 1'b0;
    logic       reset_a = 1'b1;
    logic       reset_b = 1'b1;
    logic [7:0] count_i = '0;
    logic       dir_i = 1'b0;
    logic       clr_i = 1'b0;

    logic        a_wu, a_wd, a_rv, a_je, a_de, a_obs, a_lk;
    logic [15:0] a_wc, a_rc;
    logic        b_wu, b_wd, b_rv, b_je, b_de, b_obs, b_lk;
    logic [3:0]  b_wc, b_rc;

    always #5 clk_i = ~clk_i;

    count_event_monitor dut_a (
        .clk_i(clk_i), .reset_i(reset_a), .count_i(count_i), .dir_i(dir_i), .clr_i(clr_i),
        .wrap_up_o(a_wu), .wrap_dn_o(a_wd), .reversal_o(a_rv), .jump_err_o(a_je),
        .dir_err_o(a_de), .dir_obs_o(a_obs), .locked_o(a_lk),
        .wrap_cnt_o(a_wc), .rev_cnt_o(a_rc)
    );

    count_event_monitor #(.W(8), .CW(4), .HOLD_OK(1'b0)) dut_b (
        .clk_i(clk_i), .reset_i(reset_b), .count_i(count_i), .dir_i(dir_i), .clr_i(clr_i),
        .wrap_up_o(b_wu), .wrap_dn_o(b_wd), .reversal_o(b_rv), .jump_err_o(b_je),
        .dir_err_o(b_de), .dir_obs_o(b_obs), .locked_o(b_lk),
        .wrap_cnt_o(b_wc), .rev_cnt_o(b_rc)
    );

    typedef struct {
        int          id;
        bit          sel;
        logic [4:0]  pulses;
        logic        obs;
        logic        lk;
        logic [15:0] wc;
        logic [15:0] rc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;
    bit   sel = 1'b0;

    task automatic check(input string name, input int id,
                         input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, id, act, req);
        end
    endtask

    task automatic drive(input logic rst, input logic [7:0] cnt, input logic d,
                         input logic c, input logic [4:0] p, input logic obs,
                         input logic lk, input int wc, input int rc);
        exp_t e;
        @(negedge clk_i);
        reset_a = sel ? 1'b1 : rst;
        reset_b = sel ? rst : 1'b1;
        count_i = cnt;
        dir_i   = d;
        clr_i   = c;
        e.id     = vec_id;
        e.sel    = sel;
        e.pulses = p;
        e.obs    = obs;
        e.lk     = lk;
        e.wc     = 16'(wc);
        e.rc     = 16'(rc);
        sb_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 time unit later.
    initial begin : monitor
        exp_t        e;
        logic [4:0]  p;
        logic        obs, lk;
        logic [15:0] wc, rc;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (e.sel) begin
                    p   = {b_wu, b_wd, b_rv, b_je, b_de};
                    obs = b_obs;
                    lk  = b_lk;
                    wc  = {12'b0, b_wc};
                    rc  = {12'b0, b_rc};
                end else begin
                    p   = {a_wu, a_wd, a_rv, a_je, a_de};
                    obs = a_obs;
                    lk  = a_lk;
                    wc  = a_wc;
                    rc  = a_rc;
                end
                check("pulses",   e.id, 16'(p),   16'(e.pulses));
                check("dir_obs",  e.id, 16'(obs), 16'(e.obs));
                check("locked",   e.id, 16'(lk),  16'(e.lk));
                check("wrap_cnt", e.id, wc,       e.wc);
                check("rev_cnt",  e.id, rc,       e.rc);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int k;
        int sat;

        // ---------------- dut_a: HOLD_OK=1, CW=16 ----------------
        sel = 1'b0;
        // Count up through the wrap.
        drive(1, 8'h00, 1, 0, P0, 0, 0, 0, 0);
        drive(0, 8'h00, 1, 0, P0, 0, 0, 0, 0);
        for (int i = 1; i < 256; i++) drive(0, 8'(i), 1, 0, P0, 1, 1, 0, 0);
        drive(0, 8'h00, 1, 0, P_WU, 1, 1, 1, 0);
        for (int i = 1; i <= 5; i++) drive(0, 8'(i), 1, 0, P0, 1, 1, 1, 0);

        // Up to 0x40, then direction switched to down.
        for (int i = 6; i < 8'h40; i++) drive(0, 8'(i), 1, 0, P0, 1, 1, 1, 0);
        drive(0, 8'h40, 0, 0, P0, 1, 1, 1, 0);
        drive(0, 8'h3F, 0, 0, P_RV, 0, 1, 1, 1);

        // Down through zero.
        for (int i = 8'h3E; i >= 0; i--) drive(0, 8'(i), 0, 0, P0, 0, 1, 1, 1);
        drive(0, 8'hFF, 0, 0, P_WD, 0, 1, 2, 1);

        // Down to 0x10, then a forced jump to 0x20 and relock.
        for (int i = 8'hFE; i > 8'h10; i--) drive(0, 8'(i), 0, 0, P0, 0, 1, 2, 1);
        drive(0, 8'h10, 1, 0, P0, 0, 1, 2, 1);
        drive(0, 8'h20, 1, 0, P_JE, 0, 0, 2, 1);
        drive(0, 8'h21, 1, 0, P0, 1, 1, 2, 1);
        drive(0, 8'h21, 1, 0, P0, 1, 1, 2, 1);

        // dir=1 while the count steps down.
        for (int i = 8'h22; i <= 8'h30; i++) drive(0, 8'(i), 1, 0, P0, 1, 1, 2, 1);
        drive(0, 8'h2F, 1, 0, P_RV | P_DE, 0, 1, 2, 2);
        drive(0, 8'h30, 1, 0, P_RV, 1, 1, 2, 3);

        // Jump landing on 0x00 is not a wrap; wrap_dn fires while syncing.
        drive(0, 8'h00, 1, 0, P_JE, 1, 0, 2, 3);
        drive(0, 8'hFF, 1, 0, P_WD | P_DE, 0, 1, 3, 3);

        // Clear coincident with a wrap and a reversal.
        drive(0, 8'h00, 1, 1, P_WU | P_RV, 1, 1, 0, 0);
        drive(0, 8'h01, 1, 0, P0, 1, 1, 0, 0);

        // Reset mid-operation; first sample after release is not classified.
        drive(1, 8'h02, 1, 0, P0, 0, 0, 0, 0);
        drive(0, 8'h50, 1, 0, P0, 0, 0, 0, 0);
        drive(0, 8'h51, 1, 0, P0, 1, 1, 0, 0);

        // ---------------- dut_b: HOLD_OK=0, CW=4 ----------------
        sel = 1'b1;
        drive(1, 8'h00, 1, 0, P0, 0, 0, 0, 0);
        drive(0, 8'h00, 1, 0, P0, 0, 0, 0, 0);
        drive(0, 8'h00, 1, 0, P_JE, 0, 0, 0, 0);
        drive(0, 8'h01, 1, 0, P0, 1, 1, 0, 0);
        drive(0, 8'h01, 1, 0, P_JE, 1, 0, 0, 0);
        drive(0, 8'h02, 0, 0, P0, 1, 1, 0, 0);
        drive(0, 8'h01, 0, 0, P_RV, 0, 1, 0, 1);
        drive(0, 8'h00, 0, 0, P0, 0, 1, 0, 1);

        // 20 alternating wraps; both tallies saturate at 0xF.
        for (k = 1; k <= 20; k++) begin
            sat = (k > 15) ? 15 : k;
            if (k % 2 == 1) begin
                drive(0, 8'hFF, 1, 0, (k > 1) ? (P_WD | P_RV) : P_WD, 0, 1, sat, sat);
            end else begin
                drive(0, 8'h00, 0, 0, P_WU | P_RV, 1, 1, sat, sat);
            end
        end

        // Clear with coincident wrap, then counting resumes from zero.
        drive(0, 8'hFF, 1, 1, P_WD | P_RV, 0, 1, 0, 0);
        drive(0, 8'h00, 0, 0, P_WU | P_RV, 1, 1, 1, 1);

        // Reset mid-count.
        drive(1, 8'h01, 1, 0, P0, 0, 0, 0, 0);
        drive(0, 8'h77, 1, 0, P0, 0, 0, 0, 0);
        drive(0, 8'h78, 1, 0, P0, 1, 1, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 10 && sb_q.size() != 0; n++) begin
            @(posedge clk_i);
            #2;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
